fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch engine with a circular {pc, instr} queue.
// Issues one ICache request at a time, queues responses in order, and
// flushes/restarts on redirect. In-flight responses that belong to a
// pre-redirect address are drained and dropped instead of being queued.
module fetch_queue #(
  parameter int ADDRESS_BITWIDTH     = 32,
  parameter int DATA_BITWIDTH        = 32,
  parameter int QUEUE_DEPTH_BITWIDTH = 2,
  parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        redirect,
  input  logic [ADDRESS_BITWIDTH-1:0] redirect_pc,
  input  logic                        instr_ready,
  output logic                        instr_valid,
  output logic [DATA_BITWIDTH-1:0]    instr,
  output logic [ADDRESS_BITWIDTH-1:0] instr_pc,
  output logic                        ic_enable,
  output logic [ADDRESS_BITWIDTH-1:0] ic_address,
  input  logic [DATA_BITWIDTH-1:0]    ic_data,
  input  logic                        ic_data_ready,
  input  logic                        ic_busy
);

  localparam int DEPTH = 1 << QUEUE_DEPTH_BITWIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [QUEUE_DEPTH_BITWIDTH-1:0] IDX_ONE = QUEUE_DEPTH_BITWIDTH'(1);
  localparam logic [QUEUE_DEPTH_BITWIDTH:0]   CNT_ONE = (QUEUE_DEPTH_BITWIDTH + 1)'(1);
  localparam logic [ADDRESS_BITWIDTH-1:0]     PC_STEP = ADDRESS_BITWIDTH'(4);

  logic [1:0]                      state_reg, state_next;
  logic [ADDRESS_BITWIDTH-1:0]     fetch_pc_reg;
  logic [QUEUE_DEPTH_BITWIDTH:0]   count_reg;
  logic [QUEUE_DEPTH_BITWIDTH-1:0] rd_idx_reg, wr_idx_reg, rd_idx_next;
  logic                            discard_reg;
  logic [31:0]                     stat_fetches_reg, stat_discards_reg;
  logic [ADDRESS_BITWIDTH-1:0]     head_pc_reg;
  logic [DATA_BITWIDTH-1:0]        head_instr_reg;

  logic [ADDRESS_BITWIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_BITWIDTH-1:0]    instr_mem [DEPTH];

  logic full, resp_fire, push, drop, pop;
  logic unused_pc_bits;

  // count never exceeds DEPTH, so its top bit alone marks a full queue
  assign full        = count_reg[QUEUE_DEPTH_BITWIDTH];
  assign resp_fire   = (state_reg == ST_WAIT) && ic_data_ready;
  assign push        = resp_fire && !discard_reg && !redirect;
  assign drop        = resp_fire && (discard_reg || redirect);
  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign rd_idx_next = pop ? rd_idx_reg + IDX_ONE : rd_idx_reg;

  assign instr      = head_instr_reg;
  assign instr_pc   = head_pc_reg;
  assign ic_enable  = (state_reg == ST_REQ);
  assign ic_address = ic_enable ? fetch_pc_reg : '0;

  // low address bits are word-aligned away on redirect
  assign unused_pc_bits = ^redirect_pc[1:0];

  // request sequencing: one outstanding request, drain before re-issue
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (!full && !ic_busy && !redirect) state_next = ST_REQ;
      ST_REQ:   state_next = ST_WAIT;
      ST_WAIT:  if (ic_data_ready) state_next = ST_DRAIN;
      ST_DRAIN: if (!ic_busy) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // queue storage write port (no reset, storage only)
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_idx_reg]    <= fetch_pc_reg;
      instr_mem[wr_idx_reg] <= ic_data;
    end
  end

  // control state, indices, counters and the registered head entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= ST_IDLE;
      fetch_pc_reg      <= RESET_PC;
      count_reg         <= '0;
      rd_idx_reg        <= '0;
      wr_idx_reg        <= '0;
      discard_reg       <= 1'b0;
      stat_fetches_reg  <= '0;
      stat_discards_reg <= '0;
      head_pc_reg       <= '0;
      head_instr_reg    <= '0;
    end else begin
      state_reg <= state_next;

      if (redirect) begin
        fetch_pc_reg <= {redirect_pc[ADDRESS_BITWIDTH-1:2], 2'b00};
        count_reg    <= '0;
        rd_idx_reg   <= '0;
        wr_idx_reg   <= '0;
      end else begin
        rd_idx_reg <= rd_idx_next;
        if (push) begin
          fetch_pc_reg <= fetch_pc_reg + PC_STEP;
          wr_idx_reg   <= wr_idx_reg + IDX_ONE;
        end
        if (push && !pop)      count_reg <= count_reg + CNT_ONE;
        else if (pop && !push) count_reg <= count_reg - CNT_ONE;
      end

      // the entry being written becomes head when it lands on the next read slot
      if (!redirect) begin
        if (push && (wr_idx_reg == rd_idx_next)) begin
          head_pc_reg    <= fetch_pc_reg;
          head_instr_reg <= ic_data;
        end else if (pop && (count_reg != CNT_ONE)) begin
          head_pc_reg    <= pc_mem[rd_idx_next];
          head_instr_reg <= instr_mem[rd_idx_next];
        end
      end

      if ((state_reg == ST_DRAIN) && !ic_busy)
        discard_reg <= 1'b0;
      else if (redirect && ((state_reg == ST_REQ) || (state_reg == ST_WAIT)))
        discard_reg <= 1'b1;

      if (state_reg == ST_REQ) stat_fetches_reg  <= stat_fetches_reg + 32'd1;
      if (drop)                stat_discards_reg <= stat_discards_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios with a behavioural ICache and an
// in-order scoreboard of expected {pc, instr} entries.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ic_enable;
  logic [31:0] ic_address;
  logic [31:0] ic_data = '0;
  logic        ic_data_ready = 1'b0;
  logic        ic_busy = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ena_addr_q[$];
  logic [31:0] exp_next_pc = '0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  int          pops = 0;
  int          extra_busy = 0;
  logic        busy_prev = 1'b0;

  fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_ready  (instr_ready),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .ic_enable    (ic_enable),
    .ic_address   (ic_address),
    .ic_data      (ic_data),
    .ic_data_ready(ic_data_ready),
    .ic_busy      (ic_busy)
  );

  always #5 clk = ~clk;

  // ICache / BurstRAM image
  function automatic logic [31:0] ic_word(input logic [31:0] a);
    case (a)
      32'h00:  ic_word = 32'hB7C6A980;
      32'h04:  ic_word = 32'h3F5A2E14;
      32'h08:  ic_word = 32'hAB4C3E6F;
      32'h20:  ic_word = 32'h2F5E3C7A;
      32'h44:  ic_word = 32'h0A1B2C3D;
      default: ic_word = {a[15:0] ^ 16'hC3A5, a[15:0]};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ICache model: busy from the cycle after the strobe, data two cycles later
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (ic_enable === 1'b1) begin
        a = ic_address;
        @(posedge clk); #1 ic_busy = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 ic_data = ic_word(a); ic_data_ready = 1'b1;
        @(posedge clk); #1 ic_data_ready = 1'b0;
        if (extra_busy > 0) begin
          repeat (extra_busy) @(posedge clk);
          #1;
        end
        ic_busy = 1'b0;
      end
    end
  end

  // scoreboard: push expected entries at request time, compare on pop
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        exp_next_pc = 32'h0;
      end else begin
        if (instr_valid && instr_ready && !redirect) begin
          $display("pop pc=%08h instr=%08h", instr_pc, instr);
          if (exp_q.size() == 0) begin
            check("pop_with_empty_scoreboard", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("pop_pc", instr_pc, e.pc);
            check("pop_instr", instr, e.data);
          end
          pops++;
        end
        if (ic_enable) begin
          $display("request addr=%08h", ic_address);
          check("ic_address", ic_address, exp_next_pc);
          check("ic_enable_while_busy", busy_prev, 1'b0);
          ena_addr_q.push_back(ic_address);
          if (!redirect) begin
            exp_q.push_back('{exp_next_pc, ic_word(exp_next_pc)});
            exp_next_pc = exp_next_pc + 32'd4;
          end
        end
        if (redirect) begin
          exp_q.delete();
          exp_next_pc = {redirect_pc[31:2], 2'b00};
        end
      end
      busy_prev = ic_busy;
    end
  end

  // directed stimulus
  initial begin
    int p0;
    logic found;

    // reset state
    rst = 1'b0;
    instr_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_ic_enable", ic_enable, 1'b0);
    check("rst_ic_address", ic_address, 32'h0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // S1: free-running fetch with consumer always ready
    tick(1);
    rst = 1'b1;
    for (int i = 0; i < 300 && pops < 3; i++) @(negedge clk);
    check("s1_three_pops", pops >= 3, 1'b1);
    check("s1_first_addr", (ena_addr_q.size() > 0) ? ena_addr_q[0] : 32'hFFFFFFFF, 32'h0);

    // S2: consumer stalled, queue fills to 4 then one pop frees a slot
    tick(1);
    rst = 1'b0;
    instr_ready = 1'b0;
    tick(2);
    ena_addr_q.delete();
    rst = 1'b1;
    tick(100);
    @(negedge clk);
    check("s2_request_count", 64'(ena_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("s2_request_addr", (ena_addr_q.size() > i) ? ena_addr_q[i] : 32'hFFFFFFFF, 32'(4 * i));
    check("s2_full_valid", instr_valid, 1'b1);
    check("s2_full_count", dut.count_reg, 3'd4);
    tick(1);
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    for (int i = 0; i < 100 && ena_addr_q.size() < 5; i++) @(negedge clk);
    check("s2_after_pop_addr", (ena_addr_q.size() > 4) ? ena_addr_q[4] : 32'hFFFFFFFF, 32'h10);
    tick(60);
    check("s2_no_extra_requests", 64'(ena_addr_q.size()), 64'd5);

    // S3: redirect to 0x22 while waiting on the ICache
    tick(1);
    rst = 1'b0;
    tick(2);
    ena_addr_q.delete();
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      found = ic_enable;
    end
    check("s3_request_seen", found, 1'b1);
    tick(1);
    redirect = 1'b1;
    redirect_pc = 32'h22;
    tick(1);
    redirect = 1'b0;
    tick(2);
    @(negedge clk);
    check("s3_stat_discards", dut.stat_discards_reg, 32'd1);
    check("s3_queue_empty", instr_valid, 1'b0);
    for (int i = 0; i < 60 && !instr_valid; i++) @(negedge clk);
    check("s3_head_pc", instr_pc, 32'h20);
    check("s3_head_instr", instr, 32'h2F5E3C7A);
    check("s3_next_addr", (ena_addr_q.size() > 1) ? ena_addr_q[1] : 32'hFFFFFFFF, 32'h20);

    // S4: redirect to 0x44 coinciding with a pop at count 3
    for (int i = 0; i < 200 && dut.count_reg != 3'd3; i++) tick(1);
    check("s4_count_reached", dut.count_reg, 3'd3);
    redirect = 1'b1;
    redirect_pc = 32'h44;
    instr_ready = 1'b1;
    tick(1);
    redirect = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    check("s4_count_cleared", dut.count_reg, 3'd0);
    check("s4_valid_cleared", instr_valid, 1'b0);
    for (int i = 0; i < 60 && !instr_valid; i++) @(negedge clk);
    check("s4_head_pc", instr_pc, 32'h44);
    check("s4_head_instr", instr, 32'h0A1B2C3D);

    // S5: ICache stays busy 3 cycles after each response
    tick(1);
    extra_busy = 3;
    instr_ready = 1'b1;
    p0 = pops;
    tick(80);
    check("s5_progress", pops > p0, 1'b1);

    // S6: reset during WAIT clears outputs at once, fetch restarts at 0
    instr_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = ic_enable && instr_valid;
    end
    check("s6_request_seen", found, 1'b1);
    tick(1);
    rst = 1'b0;
    #1;
    check("s6_ic_enable", ic_enable, 1'b0);
    check("s6_ic_address", ic_address, 32'h0);
    check("s6_instr_valid", instr_valid, 1'b0);
    check("s6_instr", instr, 32'h0);
    check("s6_instr_pc", instr_pc, 32'h0);
    tick(2);
    ena_addr_q.delete();
    rst = 1'b1;
    instr_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 200 && pops < p0 + 2; i++) @(negedge clk);
    check("s6_resumed_pops", pops >= p0 + 2, 1'b1);
    check("s6_first_addr", (ena_addr_q.size() > 0) ? ena_addr_q[0] : 32'hFFFFFFFF, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
